// File: rtl/q_pkg.sv
// Shared types and constants for the maze Q-learning agent's table access blocks.
package q_pkg;
   localparam int N_STATES  = 37;
   localparam int N_ACTIONS = 4;
   localparam int Q_W       = 32;
   localparam int Q_FRAC    = 16;

   typedef logic signed [Q_W-1:0] q_t;
   typedef logic [5:0]            state_t;
   typedef logic [2:0]            action_t;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} sel_state_e;

   localparam q_t Q_MIN = 32'sh8000_0000;
endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (taps 15,13,12,10), stepped only when en is high.
module lfsr16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [15:0] seed,
   output logic [15:0] q
);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)    q <= seed;
      else if (en) q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
   end
endmodule

// File: rtl/q_action_select.sv
// Epsilon-greedy action selector: scans one Q-table row for its signed max and
// picks either the argmax or an LFSR-derived exploration action.
module q_action_select #(
   parameter int          N_STATES  = q_pkg::N_STATES,
   parameter int          N_ACTIONS = q_pkg::N_ACTIONS,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic [N_STATES-1:0][N_ACTIONS-1:0][31:0]  q_table,
   input  logic [5:0]                                maze_state,
   input  logic [13:0]                               epsilon,
   input  logic                                      start,
   output logic                                      busy,
   output logic                                      done,
   output logic [2:0]                                action,
   output logic [31:0]                               max_Q,
   output logic                                      explored,
   output logic                                      bad_state
);
   import q_pkg::*;

   sel_state_e  state, nxt;
   logic        accept;
   state_t      st_r;
   logic [13:0] eps_r;
   logic [1:0]  idx;
   q_t          best_val;
   logic [1:0]  best_idx;
   logic [15:0] lfsr;
   logic        in_range;
   state_t      row_sel;
   q_t          cur;
   logic        explore;

   lfsr16 u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .en   (accept),
      .seed (LFSR_SEED),
      .q    (lfsr)
   );

   // Out-of-range rows are redirected to row 0 so the select never runs off the table;
   // in_range then suppresses the compare.
   assign in_range = (int'(st_r) < N_STATES);
   assign row_sel  = in_range ? st_r : '0;
   assign cur      = q_t'(q_table[row_sel][idx]);
   assign explore  = (lfsr[15:2] < eps_r);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= nxt;
   end

   always_comb begin
      nxt    = state;
      accept = 1'b0;
      case (state)
         IDLE: if (start) begin
            accept = 1'b1;
            nxt    = SCAN;
         end
         SCAN:    if (idx == 2'(N_ACTIONS - 1)) nxt = DONE;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_r      <= '0;
         eps_r     <= '0;
         idx       <= '0;
         best_val  <= Q_MIN;
         best_idx  <= '0;
         done      <= 1'b0;
         action    <= '0;
         max_Q     <= '0;
         explored  <= 1'b0;
         bad_state <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            st_r     <= maze_state;
            eps_r    <= epsilon;
            idx      <= '0;
            best_val <= Q_MIN;
            best_idx <= '0;
         end else if (state == SCAN) begin
            // Strict compare keeps the lowest index on ties.
            if (in_range && (cur > best_val)) begin
               best_val <= cur;
               best_idx <= idx;
            end
            idx <= idx + 2'd1;
         end else if (state == DONE) begin
            done <= 1'b1;
            if (!in_range) begin
               action    <= '0;
               max_Q     <= '0;
               explored  <= 1'b0;
               bad_state <= 1'b1;
            end else begin
               max_Q     <= best_val;
               bad_state <= 1'b0;
               explored  <= explore;
               action    <= explore ? {1'b0, lfsr[1:0]} : {1'b0, best_idx};
            end
         end
      end
   end
endmodule

// File: tb/tb_q_action_select.sv
// Directed plus randomized check of q_action_select against a row-max / epsilon model.
module tb_q_action_select;
   logic                        clk = 1'b0;
   logic                        rst = 1'b0;
   logic [36:0][3:0][31:0]      q_table;
   logic [5:0]                  maze_state = '0;
   logic [13:0]                 epsilon = '0;
   logic                        start = 1'b0;
   logic                        busy, done, explored, bad_state;
   logic [2:0]                  action;
   logic [31:0]                 max_Q;

   int          total = 0;
   int          bad = 0;
   logic [15:0] lfsr_m;

   q_action_select dut (
      .clk        (clk),
      .rst        (rst),
      .q_table    (q_table),
      .maze_state (maze_state),
      .epsilon    (epsilon),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .action     (action),
      .max_Q      (max_Q),
      .explored   (explored),
      .bad_state  (bad_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   // Reference: first-occurrence signed max of the row, then epsilon decision.
   task automatic model(input int st, input int eps, input logic [15:0] l,
                        output logic [2:0] a, output logic [31:0] mq,
                        output logic ex, output logic bs);
      int best, bi, v;
      if (st >= 37) begin
         a = 3'd0; mq = 32'd0; ex = 1'b0; bs = 1'b1;
      end else begin
         best = $signed(q_table[st][0]);
         bi   = 0;
         for (int i = 1; i < 4; i++) begin
            v = $signed(q_table[st][i]);
            if (v > best) begin best = v; bi = i; end
         end
         mq = best;
         bs = 1'b0;
         ex = (int'(l) / 4) < eps;
         a  = ex ? 3'(int'(l) % 4) : 3'(bi);
      end
   endtask

   // One operation; optionally pulses start again so it is sampled at T+2.
   task automatic run_op(input string tag, input int st, input int eps, input bit restart);
      logic [2:0]  a_e;
      logic [31:0] mq_e;
      logic        ex_e, bs_e;
      int          lat, ndone;
      @(negedge clk);
      maze_state = 6'(st);
      epsilon    = 14'(eps);
      start      = 1'b1;
      @(posedge clk);
      lfsr_m = lfsr_step(lfsr_m);
      model(st, eps, lfsr_m, a_e, mq_e, ex_e, bs_e);
      #1 start = 1'b0;
      lat = 0; ndone = 0;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         @(posedge clk);
         #1;
         if (restart && cyc == 1) start = 1'b1;
         if (restart && cyc == 2) start = 1'b0;
         if (cyc == 1) chk({tag, ".busy_scan"}, 32'(busy), 32'd1);
         if (cyc == 4) chk({tag, ".busy_last"}, 32'(busy), 32'd1);
         if (done) begin
            ndone++;
            if (lat == 0) lat = cyc;
         end
      end
      chk({tag, ".latency"}, lat, 5);
      chk({tag, ".ndone"}, ndone, 1);
      chk({tag, ".busy_after"}, 32'(busy), 32'd0);
      chk({tag, ".action"}, 32'(action), 32'(a_e));
      chk({tag, ".max_Q"}, max_Q, mq_e);
      chk({tag, ".explored"}, 32'(explored), 32'(ex_e));
      chk({tag, ".bad_state"}, 32'(bad_state), 32'(bs_e));
   endtask

   initial begin
      for (int r = 0; r < 37; r++)
         for (int c = 0; c < 4; c++)
            q_table[r][c] = $urandom;
      q_table[5][0] = 32'h0001_0000;
      q_table[5][1] = 32'h0003_8000;
      q_table[5][2] = 32'hFFFE_0000;
      q_table[5][3] = 32'h0003_0000;
      q_table[0][0] = 32'hFFFF_0000;
      q_table[0][1] = 32'hFFFF_0000;
      q_table[0][2] = 32'hFFFC_0000;
      q_table[0][3] = 32'hFFFF_0000;
      lfsr_m = 16'hACE1;

      repeat (3) @(posedge clk);
      #1;
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.done", 32'(done), 32'd0);
      chk("rst.action", 32'(action), 32'd0);
      chk("rst.max_Q", max_Q, 32'd0);
      chk("rst.explored", 32'(explored), 32'd0);
      chk("rst.bad_state", 32'(bad_state), 32'd0);
      @(negedge clk) rst = 1'b1;

      // First start after reset: LFSR 0x59C3 explores with action 3.
      run_op("explore", 5, 14'h3FFF, 1'b0);
      chk("explore.lfsr", 32'(lfsr_m), 32'h59C3);
      chk("explore.action_abs", 32'(action), 32'd3);
      chk("explore.maxq_abs", max_Q, 32'h0003_8000);
      run_op("greedy", 5, 0, 1'b0);
      chk("greedy.action_abs", 32'(action), 32'd1);
      run_op("tie_neg", 0, 0, 1'b0);
      chk("tie_neg.maxq_abs", max_Q, 32'hFFFF_0000);
      run_op("bad_st", 40, 14'h3FFF, 1'b0);
      run_op("restart", 5, 0, 1'b1);

      // Reset mid-scan: no done, outputs cleared, LFSR back to seed.
      @(negedge clk);
      maze_state = 6'd5; epsilon = 14'd0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("midrst.done", 32'(done), 32'd0);
      chk("midrst.busy", 32'(busy), 32'd0);
      chk("midrst.max_Q", max_Q, 32'd0);
      chk("midrst.action", 32'(action), 32'd0);
      repeat (4) begin
         @(posedge clk);
         #1 chk("midrst.no_done", 32'(done), 32'd0);
      end
      @(negedge clk) rst = 1'b1;
      lfsr_m = 16'hACE1;
      run_op("reexplore", 5, 14'h3FFF, 1'b0);
      chk("reexplore.lfsr", 32'(lfsr_m), 32'h59C3);
      chk("reexplore.action_abs", 32'(action), 32'd3);

      // Randomized rows (narrow values for ties), states and thresholds.
      for (int n = 0; n < 40; n++) begin
         int st, eps, sel;
         st = $urandom_range(0, 40);
         if (st < 37 && ($urandom_range(0, 1) == 1))
            for (int c = 0; c < 4; c++)
               q_table[st][c] = 32'(($urandom_range(0, 4) - 2) * 65536);
         sel = $urandom_range(0, 3);
         eps = (sel == 0) ? 0 : (sel == 1) ? 14'h3FFF : $urandom_range(0, 16383);
         run_op("rand", st, eps, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
